// File: rtl/key_beep_ctrl.sv
// Key-press beeper: each falling edge of the debounced active-low key plays
// BEEP_NUM square-wave tone bursts separated by silent gaps on a passive buzzer.
module key_beep_ctrl #(
  parameter int unsigned TONE_HALF = 12500,
  parameter int unsigned ON_CYC    = 5000000,
  parameter int unsigned OFF_CYC   = 5000000,
  parameter int unsigned BEEP_NUM  = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_filter,
  output logic beep,
  output logic busy,
  output logic done
);

  localparam int unsigned PH_MAX = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
  localparam int unsigned TW     = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
  localparam int unsigned PW     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int unsigned IW     = (BEEP_NUM > 1) ? $clog2(BEEP_NUM) : 1;

  localparam logic [TW-1:0] TONE_LAST = TW'(TONE_HALF - 1);
  localparam logic [PW-1:0] ON_LAST   = PW'(ON_CYC - 1);
  localparam logic [PW-1:0] OFF_LAST  = PW'(OFF_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(BEEP_NUM - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_key;
  logic [TW-1:0] r_tone;
  logic [PW-1:0] r_phase;
  logic [IW-1:0] r_idx;
  logic          r_beep;
  logic          r_busy;
  logic          r_done;

  state_t        w_state_nxt;
  logic [TW-1:0] w_tone_nxt;
  logic [PW-1:0] w_phase_nxt;
  logic [IW-1:0] w_idx_nxt;
  logic          w_beep_nxt;
  logic          w_done_nxt;
  logic          w_press;

  assign w_press = r_key & ~key_filter;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_key   <= 1'b1;
      r_tone  <= '0;
      r_phase <= '0;
      r_idx   <= '0;
      r_beep  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_key   <= key_filter;
      r_tone  <= w_tone_nxt;
      r_phase <= w_phase_nxt;
      r_idx   <= w_idx_nxt;
      r_beep  <= w_beep_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= w_done_nxt;
    end
  end

  // A press restarts the sequence from any state and outranks end-of-phase moves.
  always_comb begin
    w_state_nxt = r_state;
    w_tone_nxt  = r_tone;
    w_phase_nxt = r_phase;
    w_idx_nxt   = r_idx;
    w_beep_nxt  = r_beep;
    w_done_nxt  = 1'b0;
    if (w_press) begin
      w_state_nxt = S_ON;
      w_tone_nxt  = '0;
      w_phase_nxt = '0;
      w_idx_nxt   = '0;
      w_beep_nxt  = 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_tone_nxt  = '0;
          w_phase_nxt = '0;
          w_idx_nxt   = '0;
          w_beep_nxt  = 1'b0;
        end
        S_ON: begin
          if (r_phase == ON_LAST) begin
            w_beep_nxt  = 1'b0;
            w_tone_nxt  = '0;
            w_phase_nxt = '0;
            if (r_idx == IDX_LAST) begin
              w_state_nxt = S_IDLE;
              w_idx_nxt   = '0;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = S_OFF;
            end
          end else begin
            w_phase_nxt = r_phase + PW'(1);
            if (r_tone == TONE_LAST) begin
              w_tone_nxt = '0;
              w_beep_nxt = ~r_beep;
            end else begin
              w_tone_nxt = r_tone + TW'(1);
            end
          end
        end
        S_OFF: begin
          w_beep_nxt = 1'b0;
          if (r_phase == OFF_LAST) begin
            w_state_nxt = S_ON;
            w_idx_nxt   = r_idx + IW'(1);
            w_tone_nxt  = '0;
            w_phase_nxt = '0;
            w_beep_nxt  = 1'b1;
          end else begin
            w_phase_nxt = r_phase + PW'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_tone_nxt  = '0;
          w_phase_nxt = '0;
          w_idx_nxt   = '0;
          w_beep_nxt  = 1'b0;
        end
      endcase
    end
  end

  assign beep = r_beep;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_key_beep_ctrl.sv
// Scoreboard bench for key_beep_ctrl: expected outputs come from an
// elapsed-time model of the beep schedule and are checked by a monitor process.
module tb_key_beep_ctrl;

  localparam int unsigned TH  = 3;
  localparam int unsigned ONC = 12;
  localparam int unsigned OFC = 8;

  logic clk;
  logic rst_n;
  logic key_filter;
  logic beep0, busy0, done0;
  logic beep1, busy1, done1;

  key_beep_ctrl #(.TONE_HALF(TH), .ON_CYC(ONC), .OFF_CYC(OFC), .BEEP_NUM(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .key_filter(key_filter),
    .beep(beep0), .busy(busy0), .done(done0)
  );

  key_beep_ctrl #(.TONE_HALF(TH), .ON_CYC(ONC), .OFF_CYC(OFC), .BEEP_NUM(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .key_filter(key_filter),
    .beep(beep1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] e0;
    logic [2:0] e1;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model: each instance tracks only time elapsed since its last press.
  logic m_kprev;
  bit   m_act[2];
  int   m_k[2];
  exp_t pend;
  bit   pend_v = 1'b0;

  function automatic logic [2:0] sched(input int bnum, input int k);
    int len;
    int m;
    logic b;
    len = bnum * ONC + (bnum - 1) * OFC;
    if (k < len) begin
      m = k % (ONC + OFC);
      b = (m < ONC) && (((m / TH) % 2) == 0);
      return {b, 1'b1, 1'b0};
    end
    return 3'b001;
  endfunction

  task automatic model_edge(input logic key, input logic rstn,
                            output logic [2:0] e0, output logic [2:0] e1);
    logic press;
    logic [2:0] e[2];
    e[0] = 3'b000;
    e[1] = 3'b000;
    if (!rstn) begin
      m_kprev = 1'b1;
      m_act[0] = 1'b0;
      m_act[1] = 1'b0;
    end else begin
      press = m_kprev & ~key;
      m_kprev = key;
      for (int unsigned i = 0; i < 2; i++) begin
        if (press) begin
          m_act[i] = 1'b1;
          m_k[i] = 0;
        end else if (m_act[i]) begin
          m_k[i] = m_k[i] + 1;
        end
        if (m_act[i]) begin
          e[i] = sched((i == 0) ? 2 : 1, m_k[i]);
          if (e[i][0]) m_act[i] = 1'b0;
        end
      end
    end
    e0 = e[0];
    e1 = e[1];
  endtask

  // One clock cycle of stimulus; the expectation for the outputs produced by
  // these inputs is queued at the edge that registers them.
  task automatic step(input logic key, input logic rstn);
    logic [2:0] a, b;
    @(posedge clk);
    if (pend_v) q.push_back(pend);
    cyc++;
    #1;
    key_filter = key;
    rst_n = rstn;
    model_edge(key, rstn, a, b);
    pend.e0 = a;
    pend.e1 = b;
    pend.cyc = cyc + 1;
    pend_v = 1'b1;
  endtask

  task automatic hold(input logic key, input logic rstn, input int n);
    for (int unsigned j = 0; j < n; j++) step(key, rstn);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        checks++;
        if ({beep0, busy0, done0} !== x.e0) begin
          errors++;
          $display("FAIL burst2 cyc %0d beep/busy/done got %b exp %b",
                   x.cyc, {beep0, busy0, done0}, x.e0);
        end
        checks++;
        if ({beep1, busy1, done1} !== x.e1) begin
          errors++;
          $display("FAIL burst1 cyc %0d beep/busy/done got %b exp %b",
                   x.cyc, {beep1, busy1, done1}, x.e1);
        end
      end
    end
  end

  initial begin : stim
    logic k;
    logic r;
    rst_n = 1'b0;
    key_filter = 1'b1;
    m_kprev = 1'b1;
    m_act[0] = 1'b0;
    m_act[1] = 1'b0;
    m_k[0] = 0;
    m_k[1] = 0;

    hold(1'b1, 1'b0, 3);
    hold(1'b1, 1'b1, 100);
    // single press held low
    hold(1'b0, 1'b1, 40);
    hold(1'b1, 1'b1, 5);
    // release during first burst
    hold(1'b0, 1'b1, 5);
    hold(1'b1, 1'b1, 40);
    // retrigger detected during OFF (t+15)
    hold(1'b0, 1'b1, 10);
    hold(1'b1, 1'b1, 5);
    hold(1'b0, 1'b1, 40);
    hold(1'b1, 1'b1, 5);
    // press on the final ON cycle (t+32)
    hold(1'b0, 1'b1, 10);
    hold(1'b1, 1'b1, 22);
    hold(1'b0, 1'b1, 40);
    hold(1'b1, 1'b1, 5);
    // reset mid-burst with key held low through release
    hold(1'b0, 1'b1, 5);
    hold(1'b0, 1'b0, 1);
    hold(1'b0, 1'b1, 40);
    hold(1'b1, 1'b1, 5);

    k = 1'b1;
    for (int unsigned n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0) k = ~k;
      r = ($urandom_range(0, 199) != 0);
      step(k, r);
    end
    hold(1'b1, 1'b1, 2);
    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending got %0d exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
